cp0_int_ctrl: RTL and testbench
===============================

// Module: cp0_int_ctrl
// PURPOSE
//  Parametrised CP0 interrupt/exception controller for the multi-cycle CPU.
//  Replaces the fixed single-source CP0 logic with NUM_IRQ edge-triggered channels.
//  Adds per-channel mask, pending latches, fixed priority, a syscall trap and vectored entry.
//  Sits beside the datapath: the control FSM samples int_req at instruction boundaries,
//  pulses int_ack with the return PC, and loads int_vector into PC. eret restores from epc.
// PARAMETERS
//  NUM_IRQ     8       number of external interrupt channels (1..16)
//  DW          32      CP0 register / PC width
//  BASE_RESET  32'h80  reset value of the base register (reg 15)
//  VEC_SHIFT   4       vector spacing = 2**VEC_SHIFT bytes per cause code
// PORTS
//  clk         in   1        system clock, all state updates on posedge
//  reset       in   1        synchronous, active-high
//  irq         in   NUM_IRQ  level inputs; a rising edge requests service
//  syscall     in   1        1-cycle pulse from control FSM on a SYSCALL instruction
//  int_ack     in   1        CPU takes the current request this cycle
//  pc_in       in   DW       return address, captured into epc on an accepted int_ack
//  eret        in   1        1-cycle pulse: return from handler
//  cp0_we      in   1        mtc0 write strobe
//  cp0_waddr   in   5        mtc0 register number (11..15)
//  cp0_wdata   in   DW       mtc0 data
//  cp0_raddr   in   5        mfc0 register number
//  cp0_rdata   out  DW       mfc0 data, registered
//  int_req     out  1        request pending and allowed
//  int_vector  out  DW       handler entry address for the current winner
//  epc         out  DW       current epc register (eret target)
//  int_enable  out  1        global enable (enable[31])
// BEHAVIOUR
//  Registers:
//  - 11 enable: [31]=IE, [NUM_IRQ-1:0]=mask.
//  - 12 status: [NUM_IRQ-1:0]=pending (write 1 to clear), [30]=syscall pending,
//    [31]=in_service (read-only).
//  - 13 cause: [7:0]=code. 8'h08=syscall; 8'h10+i=irq i.
//  - 14 epc.
//  - 15 base.
//  - Other addresses: writes ignored, reads return 0.
//  Reset: all registers, irq_prev, state and cp0_rdata = 0; base = BASE_RESET.
//  Outputs at reset: int_req=0, int_enable=0, epc=0, int_vector=BASE_RESET.
//  Edge detect:
//  - irq_prev <= irq each cycle; pending[i] is set when irq[i] & ~irq_prev[i].
//  - Channel i is eligible when pending[i] & mask[i] & IE.
//  - Timing: irq rises before edge n -> pending=1 after edge n -> int_req=1 in cycle n+1.
//  Syscall: a syscall pulse sets sys_pend. sys_pend is not gated by IE or mask.
//  Priority: sys_pend first, then the lowest eligible irq index.
//  int_req = sys_pend | any eligible channel (combinational from registers).
//  int_vector = base + (code << VEC_SHIFT), combinational. code is the winner code, 0 if none.
//  FSM: IDLE, SERVICE.
//  - IDLE -> SERVICE on int_ack & int_req.
//    Same edge: epc<=pc_in, cause<=winner code, IE<=0, winner's pending/sys_pend cleared.
//  - SERVICE -> IDLE on eret. Same edge: IE<=1.
//  - SERVICE + accepted int_ack (nesting, possible after software sets IE or a syscall):
//    same captures as above, state stays SERVICE. epc is overwritten; software saves it first.
//  - eret in IDLE: ignored.
//  Ignored / conflicting events:
//  - int_ack while int_req=0: ignored, no state change.
//  - int_ack and eret in the same cycle: ack wins, eret dropped.
//  - New edge on the channel being acked in the same cycle: set wins, pending stays 1.
//    Same set-wins rule for a write-1-to-clear racing a new edge.
//  - mtc0 to the same register as a hardware update in the same cycle:
//    hardware wins for IE/epc/cause. mtc0 to other registers completes normally.
//  cp0_rdata <= reg[cp0_raddr] each cycle (1-cycle latency). Shows pre-edge values on
//  same-cycle write.
//  Reset asserted mid-service: returns to IDLE with all registers at reset values.
//  Pending edges are lost.
// TESTING
//  1. reset; mtc0 11=32'h8000_0001; irq[0] 0->1 -> int_req=1 next cycle, int_vector=32'h180.
//     Ack with pc_in=32'h40 -> epc=32'h40, cause=8'h10, IE=0, int_req=0, state SERVICE.
//  2. mask=8'hFF, IE=1; rising edges on irq[5] and irq[2] together -> irq 2 wins
//     (cause 8'h12). After eret, irq 5 is served (cause 8'h15, vector 32'h80+32'h150=32'h1D0).
//  3. IE=0, syscall pulse -> int_req=1, code 8'h08, vector 32'h100.
//     Ack -> sys_pend=0. eret -> IE=1, state IDLE.
//  4. irq[3] held high for 10 cycles with mask bit clear -> no int_req.
//     Set mask -> int_req (pending latched). Level held after ack -> no re-request.
//  5. int_ack with int_req=0 -> nothing changes. Ack and eret same cycle -> ack taken,
//     state stays SERVICE.
//  6. Reset asserted during SERVICE with pending bits set -> all regs zero, base=32'h80,
//     int_req=0. mfc0 15 -> 32'h80 one cycle later.

Source files
------------

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception controller: NUM_IRQ edge-triggered channels plus a syscall trap,
// fixed priority (syscall, then lowest irq), vectored entry at base + (code << VEC_SHIFT).
module cp0_int_ctrl #(
  parameter int              NUM_IRQ    = 8,
  parameter int              DW         = 32,
  parameter logic [DW-1:0]   BASE_RESET = 'h80,
  parameter int              VEC_SHIFT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               syscall,
  input  logic               int_ack,
  input  logic [DW-1:0]      pc_in,
  input  logic               eret,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_waddr,
  input  logic [DW-1:0]      cp0_wdata,
  input  logic [4:0]         cp0_raddr,
  output logic [DW-1:0]      cp0_rdata,
  output logic               int_req,
  output logic [DW-1:0]      int_vector,
  output logic [DW-1:0]      epc,
  output logic               int_enable
);

  localparam logic [4:0] ADDR_ENABLE = 5'd11;
  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] ADDR_BASE   = 5'd15;

  localparam logic [7:0] CODE_SYSCALL = 8'h08;
  localparam logic [7:0] CODE_IRQ0    = 8'h10;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t             state_q,    state_d;
  logic               ie_q,       ie_d;
  logic [NUM_IRQ-1:0] mask_q,     mask_d;
  logic [NUM_IRQ-1:0] pending_q,  pending_d;
  logic               sys_pend_q, sys_pend_d;
  logic [7:0]         cause_q,    cause_d;
  logic [DW-1:0]      epc_q,      epc_d;
  logic [DW-1:0]      base_q,     base_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [DW-1:0]      rdata_q,    rdata_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [7:0]         win_code;
  logic               req;
  logic               accept;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [DW-1:0]      vec_offset;
  logic               wr_enable, wr_status, wr_cause, wr_epc, wr_base;
  logic               unused_wdata;

  assign unused_wdata = ^cp0_wdata;

  // Winner selection: scan high to low so the lowest eligible index is left standing.
  always_comb begin
    eligible   = pending_q & mask_q & {NUM_IRQ{ie_q}};
    win_onehot = '0;
    win_code   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_code      = CODE_IRQ0 + 8'(i);
      end
    end
    if (sys_pend_q) begin
      win_onehot = '0;
      win_code   = CODE_SYSCALL;
    end
    req = sys_pend_q | (|eligible);
  end

  assign vec_offset = {{(DW-8){1'b0}}, win_code} << VEC_SHIFT;
  assign accept     = int_ack & req;
  assign irq_rise   = irq & ~irq_prev_q;

  assign wr_enable = cp0_we & (cp0_waddr == ADDR_ENABLE);
  assign wr_status = cp0_we & (cp0_waddr == ADDR_STATUS);
  assign wr_cause  = cp0_we & (cp0_waddr == ADDR_CAUSE);
  assign wr_epc    = cp0_we & (cp0_waddr == ADDR_EPC);
  assign wr_base   = cp0_we & (cp0_waddr == ADDR_BASE);

  // Software writes first, hardware updates override, new edges override clears.
  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    mask_d     = mask_q;
    pending_d  = pending_q;
    sys_pend_d = sys_pend_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    base_d     = base_q;
    irq_prev_d = irq;

    if (wr_enable) begin
      ie_d   = cp0_wdata[31];
      mask_d = cp0_wdata[NUM_IRQ-1:0];
    end
    if (wr_status) begin
      pending_d = pending_d & ~cp0_wdata[NUM_IRQ-1:0];
      if (cp0_wdata[30]) begin
        sys_pend_d = 1'b0;
      end
    end
    if (wr_cause) begin
      cause_d = cp0_wdata[7:0];
    end
    if (wr_epc) begin
      epc_d = cp0_wdata;
    end
    if (wr_base) begin
      base_d = cp0_wdata;
    end

    if (accept) begin
      state_d   = SERVICE;
      epc_d     = pc_in;
      cause_d   = win_code;
      ie_d      = 1'b0;
      pending_d = pending_d & ~win_onehot;
      if (sys_pend_q) begin
        sys_pend_d = 1'b0;
      end
    end else if (eret && state_q == SERVICE) begin
      state_d = IDLE;
      ie_d    = 1'b1;
    end

    pending_d = pending_d | irq_rise;
    if (syscall) begin
      sys_pend_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (cp0_raddr)
      ADDR_ENABLE: begin
        rdata_d[31]          = ie_q;
        rdata_d[NUM_IRQ-1:0] = mask_q;
      end
      ADDR_STATUS: begin
        rdata_d[31]          = (state_q == SERVICE);
        rdata_d[30]          = sys_pend_q;
        rdata_d[NUM_IRQ-1:0] = pending_q;
      end
      ADDR_CAUSE: rdata_d[7:0] = cause_q;
      ADDR_EPC:   rdata_d      = epc_q;
      ADDR_BASE:  rdata_d      = base_q;
      default:    rdata_d      = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ie_q       <= 1'b0;
      mask_q     <= '0;
      pending_q  <= '0;
      sys_pend_q <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      base_q     <= BASE_RESET;
      irq_prev_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      sys_pend_q <= sys_pend_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      base_q     <= base_d;
      irq_prev_q <= irq_prev_d;
      rdata_q    <= rdata_d;
    end
  end

  assign cp0_rdata  = rdata_q;
  assign int_req    = req;
  assign int_vector = base_q + vec_offset;
  assign epc        = epc_q;
  assign int_enable = ie_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: per-cycle comparison against a register-level model, plus directed literal checks.
module tb_cp0_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        syscall, int_ack, eret, cp0_we;
  logic [31:0] pc_in, cp0_wdata;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_rdata, int_vector, epc;
  logic        int_req, int_enable;

  int checks = 0;
  int errors = 0;

  cp0_int_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .syscall(syscall), .int_ack(int_ack),
    .pc_in(pc_in), .eret(eret), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .int_req(int_req), .int_vector(int_vector), .epc(epc), .int_enable(int_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: architectural registers as seen by software.
  bit        m_ok = 0;
  bit        m_ie, m_svc, m_sys;
  bit        m_mask [8];
  bit        m_pend [8];
  bit        m_prev [8];
  int        m_cause;
  logic [31:0] m_epc, m_base, m_rdata;

  function automatic int m_code();
    if (m_sys) return 8;
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && m_mask[i] && m_ie) return 16 + i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v = 0;
    case (a)
      11: begin v[31] = m_ie; for (int i = 0; i < 8; i++) v[i] = m_mask[i]; end
      12: begin v[31] = m_svc; v[30] = m_sys; for (int i = 0; i < 8; i++) v[i] = m_pend[i]; end
      13: v = m_cause;
      14: v = m_epc;
      15: v = m_base;
      default: v = 0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1; m_ie = 0; m_svc = 0; m_sys = 0; m_cause = 0;
      m_epc = 0; m_base = 32'h80; m_rdata = 0;
      for (int i = 0; i < 8; i++) begin m_mask[i] = 0; m_pend[i] = 0; m_prev[i] = 0; end
    end else if (m_ok) begin
      int code;
      bit rise [8];
      code = m_code();
      m_rdata = m_read(cp0_raddr);
      for (int i = 0; i < 8; i++) begin
        rise[i] = irq[i] && !m_prev[i];
        m_prev[i] = irq[i];
      end
      if (cp0_we) begin
        case (cp0_waddr)
          11: begin m_ie = cp0_wdata[31]; for (int i = 0; i < 8; i++) m_mask[i] = cp0_wdata[i]; end
          12: begin
            for (int i = 0; i < 8; i++) if (cp0_wdata[i]) m_pend[i] = 0;
            if (cp0_wdata[30]) m_sys = 0;
          end
          13: m_cause = cp0_wdata[7:0];
          14: m_epc = cp0_wdata;
          15: m_base = cp0_wdata;
          default: ;
        endcase
      end
      if (int_ack && code != 0) begin
        m_svc = 1; m_epc = pc_in; m_cause = code; m_ie = 0;
        if (code == 8) m_sys = 0;
        else m_pend[code - 16] = 0;
      end else if (eret && m_svc) begin
        m_svc = 0; m_ie = 1;
      end
      for (int i = 0; i < 8; i++) if (rise[i]) m_pend[i] = 1;
      if (syscall) m_sys = 1;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_int_req", {31'd0, int_req}, {31'd0, m_code() != 0});
      chk("m_int_vector", int_vector, m_base + 32'(m_code() * 16));
      chk("m_epc", epc, m_epc);
      chk("m_int_enable", {31'd0, int_enable}, {31'd0, m_ie});
      chk("m_cp0_rdata", cp0_rdata, m_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    syscall = 0; int_ack = 0; eret = 0; cp0_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    cyc();
  endtask

  initial begin
    reset = 1; irq = 0; syscall = 0; int_ack = 0; eret = 0; cp0_we = 0;
    pc_in = 0; cp0_wdata = 0; cp0_waddr = 0; cp0_raddr = 0;
    cyc(); cyc();
    reset = 0;
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    chk("rst_int_vector", int_vector, 32'h80);
    chk("rst_epc", epc, 32'h0);
    chk("rst_int_enable", {31'd0, int_enable}, 32'd0);

    // 1: single channel, vector and ack captures
    mtc0(11, 32'h8000_0001);
    irq = 8'h01; cyc(); irq = 8'h00;
    chk("t1_req", {31'd0, int_req}, 32'd1);
    chk("t1_vec", int_vector, 32'h180);
    pc_in = 32'h40; int_ack = 1; cyc();
    chk("t1_epc", epc, 32'h40);
    chk("t1_ie", {31'd0, int_enable}, 32'd0);
    chk("t1_req_after", {31'd0, int_req}, 32'd0);
    cp0_raddr = 13; cyc();
    chk("t1_cause", cp0_rdata, 32'h10);
    cp0_raddr = 12; cyc();
    chk("t1_status", cp0_rdata, 32'h8000_0000);
    eret = 1; cyc();

    // 2: simultaneous edges, lower index first
    mtc0(11, 32'h8000_00FF);
    irq = 8'h24; cyc(); irq = 8'h00;
    chk("t2_vec_irq2", int_vector, 32'h1A0);
    pc_in = 32'h100; int_ack = 1; cyc();
    chk("t2_req_masked_by_ie", {31'd0, int_req}, 32'd0);
    cp0_raddr = 13; cyc();
    chk("t2_cause2", cp0_rdata, 32'h12);
    eret = 1; cyc();
    chk("t2_req_irq5", {31'd0, int_req}, 32'd1);
    chk("t2_vec_irq5", int_vector, 32'h1D0);
    pc_in = 32'h104; int_ack = 1; cyc();
    cyc();
    chk("t2_cause5", cp0_rdata, 32'h15);
    eret = 1; cyc();

    // 3: syscall ignores IE
    mtc0(11, 32'h0000_00FF);
    syscall = 1; cyc();
    chk("t3_req", {31'd0, int_req}, 32'd1);
    chk("t3_vec", int_vector, 32'h100);
    pc_in = 32'h200; int_ack = 1; cyc();
    cp0_raddr = 12; cyc();
    chk("t3_status", cp0_rdata, 32'h8000_0000);
    eret = 1; cyc();
    chk("t3_ie", {31'd0, int_enable}, 32'd1);
    cyc();
    chk("t3_status_idle", cp0_rdata, 32'h0);

    // 4: masked level, latched pending, no re-request while held
    mtc0(11, 32'h8000_0000);
    irq = 8'h08;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_masked", {31'd0, int_req}, 32'd0);
    end
    mtc0(11, 32'h8000_0008);
    chk("t4_req", {31'd0, int_req}, 32'd1);
    chk("t4_vec", int_vector, 32'h1B0);
    pc_in = 32'h300; int_ack = 1; cyc();
    eret = 1; cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_held", {31'd0, int_req}, 32'd0);
    end
    irq = 8'h00; cyc();

    // 5: stray ack ignored; ack beats eret; hardware beats mtc0 on epc
    pc_in = 32'hDEAD; int_ack = 1; cyc();
    chk("t5_epc_kept", epc, 32'h300);
    chk("t5_ie_kept", {31'd0, int_enable}, 32'd1);
    syscall = 1; cyc();
    int_ack = 1; eret = 1; pc_in = 32'h500;
    cp0_we = 1; cp0_waddr = 14; cp0_wdata = 32'h999;
    cyc();
    chk("t5_epc_hw", epc, 32'h500);
    chk("t5_ie", {31'd0, int_enable}, 32'd0);
    cp0_raddr = 12; cyc();
    chk("t5_in_service", cp0_rdata, 32'h8000_0000);

    // 6: pending set, w1c, then reset mid-service
    mtc0(11, 32'h0000_00FF);
    irq = 8'h81; cyc(); irq = 8'h00;
    cyc();
    chk("t6_status", cp0_rdata, 32'h8000_0081);
    mtc0(12, 32'h0000_0001);
    cyc();
    chk("t6_w1c", cp0_rdata, 32'h8000_0080);
    reset = 1; cp0_raddr = 15; cyc(); cyc();
    chk("t6_rdata_rst", cp0_rdata, 32'h0);
    chk("t6_req_rst", {31'd0, int_req}, 32'd0);
    chk("t6_epc_rst", epc, 32'h0);
    chk("t6_vec_rst", int_vector, 32'h80);
    reset = 0; cyc();
    chk("t6_base", cp0_rdata, 32'h80);
    cp0_raddr = 12; cyc();
    chk("t6_status_rst", cp0_rdata, 32'h0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
